bcd_to_hex: RTL
===============

# bcd_to_hex

Sequential BCD-to-binary converter that accepts a packed six-digit decimal value and returns its 20-bit binary equivalent using reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more. It is the inverse of the display-path binary-to-BCD converter. It sits between decimal entry sources (keypad or switch digits) and the binary datapath. Valid/ready handshakes on both sides; one conversion in flight at a time.

## Interface
- DIGITS, 6, number of BCD digits accepted
- BIN_W, 20, result width; must satisfy 2^BIN_W > 10^DIGITS - 1
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- bcd_in  input  4*DIGITS  packed digits; digit k at [4k+3:4k], digit 0 least significant
- in_valid  input  1  bcd_in is valid
- in_ready  output  1  block is idle and will accept bcd_in
- hex_number  output  BIN_W  converted binary result
- error  output  1  last accepted input contained a digit greater than 9
- out_valid  output  1  hex_number/error are valid
- out_ready  input  1  consumer accepts the result

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - If any digit is greater than 9: set error=1 and hex_number=0, then go to DONE.
  - Otherwise: load the BCD shift register with bcd_in, clear the binary register and counter, clear error, then go to SHIFT.
- SHIFT: each cycle, shift {bcd_reg, bin_reg} right by 1 as one (4*DIGITS+BIN_W)-bit word; bcd_reg LSB enters bin_reg MSB. Then apply to every digit of the shifted bcd_reg: if the digit is 8 or more, subtract 3. Increment the counter.
- After BIN_W shifts: copy bin_reg to hex_number and go to DONE.
- DONE: out_valid=1. hex_number and error stay stable until out_valid&&out_ready, then go to IDLE.
- in_valid is ignored outside IDLE. No input queuing.
- hex_number and error keep their last values after the handshake, until the next completion.
- Arithmetic: all digit operations are 4-bit unsigned. The subtract-3 never underflows because it applies only when the digit is 8 or more. After the final shift bcd_reg must be all zero; a nonzero bcd_reg is an assertion failure in simulation.

## Timing
- Reset (asserted low, asynchronous) forces:
  - state IDLE, counter 0, bcd_reg 0, bin_reg 0
  - hex_number=0, error=0, out_valid=0, in_ready=1
- Reset mid-SHIFT or mid-DONE aborts the conversion; the result is discarded.
- Valid input accepted at edge N: SHIFT occupies edges N+1..N+BIN_W; out_valid is high after edge N+BIN_W. Latency is 20 cycles with defaults.
- Invalid input accepted at edge N: out_valid is high after edge N+1.
- Result consumed at edge M: in_ready is high after edge M. Sustained throughput is one conversion per BIN_W+2 cycles.
- in_ready and out_valid are decoded from state registers only, with no combinational path from inputs.
- out_ready held high continuously: DONE lasts exactly one cycle.
- Simultaneous in_valid during DONE: ignored; the input must be held until in_ready.

## Structure
- Package bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE}
  - BCD_DIGIT_MAX=9, ADJ_THRESH=8, ADJ_VALUE=3
  - the shared digit-width constant 4, also used by the binary-to-BCD converter
- Sub-module bcd_digit_adjust: combinational, 4-bit in and out, subtracts 3 when the input is 8 or more. Instantiated DIGITS times by generate.
- Counter width: $clog2(BIN_W+1).

## Test plan
- bcd_in=0x999999, out_ready=1 -> hex_number=0xF423F, error=0, out_valid exactly 20 cycles after accept.
- bcd_in=0x000000 -> hex_number=0x00000. Then bcd_in=0x123456 -> hex_number=0x1E240. in_ready low for the whole conversion.
- bcd_in=0x12A456 -> error=1, hex_number=0, out_valid one cycle after accept. The next valid input clears error.
- out_ready held low 10 cycles after 0x000255 completes -> hex_number=0x000FF stable and in_ready=0 throughout. New in_valid pulses during the stall are ignored.
- reset pulsed low at shift 7 of 0x654321 -> all outputs at reset values immediately (asynchronous). A following 0x000001 converts to 0x00001.
- Random 2000 valid 6-digit inputs with random out_ready backpressure -> every hex_number equals the decimal value of bcd_in, and no completion is dropped or duplicated.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the decimal/binary conversion blocks.
// The digit width is shared with the binary-to-BCD display-path converter.
package bcd_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;
   localparam logic [DIGIT_W-1:0] ADJ_THRESH    = 4'd8;
   localparam logic [DIGIT_W-1:0] ADJ_VALUE     = 4'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble digit correction: subtract 3 from a digit of 8 or more.
// Purely combinational; the subtraction cannot underflow because of the threshold.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] digit_o
);

   assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_VALUE) : digit_i;

endmodule

// File: rtl/bcd_to_hex.sv
// Sequential packed-BCD to binary converter (reverse double-dabble), one conversion in flight.
// Latency BIN_W cycles for valid input, 1 cycle for a bad digit; result held until out_ready.
module bcd_to_hex
   import bcd_pkg::*;
#(
   parameter int DIGITS = 6,
   parameter int BIN_W  = 20
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [BIN_W-1:0]          hex_number,
   output logic                      error,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [BIN_W-1:0]   hex_q, hex_d;
   logic               err_q, err_d;

   logic [BCD_W-1:0]   bcd_shift;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BIN_W-1:0]   bin_shift;
   logic [DIGITS-1:0]  digit_bad;
   logic               bad_input;
   logic               last_shift;

   // {bcd, bin} moves right as one word; the BCD LSB feeds the binary MSB.
   assign bcd_shift = bcd_q >> 1;
   assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_adjust u_adj (
         .digit_i (bcd_shift[g*DIGIT_W +: DIGIT_W]),
         .digit_o (bcd_adj[g*DIGIT_W +: DIGIT_W])
      );

      assign digit_bad[g] = (bcd_in[g*DIGIT_W +: DIGIT_W] > BCD_DIGIT_MAX);
   end

   assign bad_input  = |digit_bad;
   assign last_shift = (cnt_q == LAST_CNT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      hex_d   = hex_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = SHIFT;
               bin_d   = '0;
               if (bad_input) begin
                  // Zeroed registers and a preloaded counter make the next
                  // SHIFT cycle the last one, giving a one-cycle error path.
                  err_d = 1'b1;
                  hex_d = '0;
                  bcd_d = '0;
                  cnt_d = LAST_CNT;
               end else begin
                  err_d = 1'b0;
                  bcd_d = bcd_in;
                  cnt_d = '0;
               end
            end
         end

         SHIFT: begin
            bcd_d = bcd_adj;
            bin_d = bin_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_shift) begin
               hex_d   = bin_shift;
               state_d = DONE;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bcd_q   <= '0;
         bin_q   <= '0;
         hex_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         hex_q   <= hex_d;
         err_q   <= err_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign hex_number = hex_q;
   assign error      = err_q;

   // Every BCD bit must have drained into the binary register by the final shift.
   a_bcd_drained : assert property (
      @(posedge clk) disable iff (!reset)
      (state_q == SHIFT && last_shift) |-> (bcd_adj == '0)
   );

endmodule
